// File: rtl/pid_core_param.sv
// Parametrised P/I/D controller with one time-shared multiplier.
// Optional output slew limiting: define PID_SLEW_LIMIT_EN.
module pid_core_param #(
  parameter int W        = 8,
  parameter int GW       = 8,
  parameter int FRAC     = 4,
  parameter int ACC_W    = 24,
  parameter int INT_LIM  = 32767,
  parameter int SLEW_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          sample_valid,
  output logic          sample_ready,
  input  logic [W-1:0]  setpoint,
  input  logic [W-1:0]  feedback,
  input  logic [GW-1:0] kp,
  input  logic [GW-1:0] ki,
  input  logic [GW-1:0] kd,
  output logic          out_valid,
  output logic [W-1:0]  control_out,
  output logic          saturated
);

`ifdef PID_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam logic signed [ACC_W:0]   LIM  = (ACC_W+1)'(INT_LIM);
  localparam logic signed [ACC_W+1:0] OMAX = (ACC_W+2)'((1 << W) - 1);
  localparam logic signed [W+1:0]     SL   = (W+2)'(SLEW_MAX);

  typedef enum logic [2:0] {
    IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  sp_q, fb_q;
  logic [GW-1:0] kp_q, ki_q, kd_q;
  logic signed [W:0]   err_q, perr_q, err_c;
  logic signed [W+1:0] der_q, der_c;
  logic signed [ACC_W-1:0] p_q, i_q, d_q;
  logic signed [ACC_W-1:0] mul_g, mul_x, prod;
  logic signed [ACC_W:0]   isum;
  logic signed [ACC_W-1:0] i_c;
  logic signed [ACC_W+1:0] tot, sh;
  logic [W-1:0] rng, out_c;
  logic rsat, sat_c;
  logic signed [W+1:0] cur, tgt, hi, lo;
  logic accept;

  assign sample_ready = (state == IDLE);
  assign accept = sample_valid && sample_ready;

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (sample_valid) state_nx = ERR;
        ERR:     state_nx = MUL_P;
        MUL_P:   state_nx = MUL_I;
        MUL_I:   state_nx = MUL_D;
        MUL_D:   state_nx = SUM;
        SUM:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign err_c = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
  assign der_c = {err_c[W], err_c} - {perr_q[W], perr_q};

  // Gains are unsigned: zero-extend them; error terms sign-extend.
  always_comb begin
    mul_g = '0;
    mul_x = '0;
    unique case (state)
      MUL_P: begin
        mul_g = $signed({{(ACC_W-GW){1'b0}}, kp_q});
        mul_x = {{(ACC_W-W-1){err_q[W]}}, err_q};
      end
      MUL_I: begin
        mul_g = $signed({{(ACC_W-GW){1'b0}}, ki_q});
        mul_x = {{(ACC_W-W-1){err_q[W]}}, err_q};
      end
      MUL_D: begin
        mul_g = $signed({{(ACC_W-GW){1'b0}}, kd_q});
        mul_x = {{(ACC_W-W-2){der_q[W+1]}}, der_q};
      end
      default: ;
    endcase
  end

  assign prod = mul_g * mul_x;
  assign isum = {i_q[ACC_W-1], i_q} + {prod[ACC_W-1], prod};

  always_comb begin
    i_c = isum[ACC_W-1:0];
    if (isum > LIM)       i_c = LIM[ACC_W-1:0];
    else if (isum < -LIM) i_c = (-LIM);
  end

  assign tot = {{2{p_q[ACC_W-1]}}, p_q}
             + {{2{i_q[ACC_W-1]}}, i_q}
             + {{2{d_q[ACC_W-1]}}, d_q};
  assign sh = tot >>> FRAC;

  always_comb begin
    rng  = sh[W-1:0];
    rsat = 1'b0;
    if (sh[ACC_W+1]) begin
      rng  = '0;
      rsat = 1'b1;
    end else if (sh > OMAX) begin
      rng  = '1;
      rsat = 1'b1;
    end
  end

  always_comb begin
    out_c = rng;
    sat_c = rsat;
    cur   = $signed({2'b00, control_out});
    tgt   = $signed({2'b00, rng});
    hi    = cur + SL;
    lo    = cur - SL;
    if (SLEW_EN && tgt > hi) begin
      out_c = hi[W-1:0];
      sat_c = 1'b1;
    end else if (SLEW_EN && tgt < lo) begin
      out_c = lo[W-1:0];
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0; fb_q <= '0;
      kp_q <= '0; ki_q <= '0; kd_q <= '0;
      err_q <= '0; perr_q <= '0; der_q <= '0;
      p_q <= '0; i_q <= '0; d_q <= '0;
      control_out <= '0;
      saturated <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        i_q    <= '0;
        perr_q <= '0;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            sp_q <= setpoint; fb_q <= feedback;
            kp_q <= kp; ki_q <= ki; kd_q <= kd;
          end
          ERR: begin
            err_q <= err_c;
            der_q <= der_c;
          end
          MUL_P: p_q <= prod;
          MUL_I: i_q <= i_c;
          MUL_D: d_q <= prod;
          SUM: begin
            control_out <= out_c;
            saturated   <= sat_c;
            out_valid   <= 1'b1;
            perr_q      <= err_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_core_param.sv
// Bench for pid_core_param: directed and random samples against
// a behavioural model, on a default and a low-INT_LIM instance.
module tb_pid_core_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic sample_valid = 1'b0;
  logic [7:0] setpoint = '0, feedback = '0;
  logic [7:0] kp = '0, ki = '0, kd = '0;
  logic sample_ready, out_valid, saturated;
  logic [7:0] control_out;
  logic l_ready, l_valid, l_sat;
  logic [7:0] l_out;

  int tests = 0;
  int fails = 0;

  longint m_int[2];
  longint m_prev;
  longint m_out[2];
  bit m_sat[2];
  longint lims[2] = '{32767, 1000};

  always #5 clk = ~clk;

  pid_core_param u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .setpoint(setpoint), .feedback(feedback),
    .kp(kp), .ki(ki), .kd(kd),
    .out_valid(out_valid), .control_out(control_out),
    .saturated(saturated)
  );

  pid_core_param #(.INT_LIM(1000)) u_lim (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .sample_valid(sample_valid), .sample_ready(l_ready),
    .setpoint(setpoint), .feedback(feedback),
    .kp(kp), .ki(ki), .kd(kd),
    .out_valid(l_valid), .control_out(l_out),
    .saturated(l_sat)
  );

  task automatic model_reset();
    m_int = '{0, 0}; m_prev = 0;
    m_out = '{0, 0}; m_sat = '{0, 0};
  endtask

  task automatic model_clear();
    m_int = '{0, 0}; m_prev = 0;
  endtask

  task automatic model_step(input longint sp, fb, gp, gi, gd);
    longint err, der, s, o;
    bit sat;
    err = sp - fb;
    der = err - m_prev;
    for (int j = 0; j < 2; j++) begin
      m_int[j] = m_int[j] + gi * err;
      if (m_int[j] > lims[j]) m_int[j] = lims[j];
      if (m_int[j] < -lims[j]) m_int[j] = -lims[j];
      s = (gp * err + m_int[j] + gd * der) >>> 4;
      sat = 1'b0;
      o = s;
      if (s < 0) begin o = 0; sat = 1'b1; end
      else if (s > 255) begin o = 255; sat = 1'b1; end
`ifdef PID_SLEW_LIMIT_EN
      if (o > m_out[j] + 16) begin o = m_out[j] + 16; sat = 1'b1; end
      else if (o < m_out[j] - 16) begin o = m_out[j] - 16; sat = 1'b1; end
`endif
      m_out[j] = o;
      m_sat[j] = sat;
    end
    m_prev = err;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  // Drives one handshake and reports latency and ready behaviour.
  task automatic xfer(input logic [7:0] sp, fb, gp, gi, gd,
                      output int lat, output bit rdy_ok,
                      output bit lv_ok);
    @(negedge clk);
    setpoint = sp; feedback = fb; kp = gp; ki = gi; kd = gd;
    sample_valid = 1'b1;
    rdy_ok = (sample_ready === 1'b1);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    lat = -1;
    lv_ok = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = c;
        lv_ok = (l_valid === 1'b1);
        break;
      end
      if (sample_ready !== 1'b0) rdy_ok = 1'b0;
    end
    model_step(sp, fb, gp, gi, gd);
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (sample_ready !== 1'b1 || out_valid !== 1'b0 ||
        control_out !== 8'd0 || saturated !== 1'b0) begin
      fails++;
      $display("FAIL reset got rdy=%b ov=%b out=%0d sat=%b exp 1 0 0 0",
               sample_ready, out_valid, control_out, saturated);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_prop();
    int lat; bit rdy, lv;
    xfer(8'd100, 8'd60, 8'd32, 8'd0, 8'd0, lat, rdy, lv);
    tests++;
    if (lat !== 5) begin
      fails++; $display("FAIL prop_latency got %0d exp 5", lat);
    end
    tests++;
    if (!rdy) begin
      fails++; $display("FAIL prop_ready got high exp low while busy");
    end
    tests++;
    if (control_out !== m_out[0][7:0] || saturated !== m_sat[0]) begin
      fails++;
      $display("FAIL prop_out got %0d/%b exp %0d/%b",
               control_out, saturated, m_out[0], m_sat[0]);
    end
`ifndef PID_SLEW_LIMIT_EN
    tests++;
    if (control_out !== 8'd80) begin
      fails++; $display("FAIL prop_literal got %0d exp 80", control_out);
    end
`endif
  endtask

  task automatic test_saturate();
    int lat; bit rdy, lv;
    logic [7:0] sps[2] = '{8'd10, 8'd255};
    logic [7:0] fbs[2] = '{8'd200, 8'd0};
    for (int i = 0; i < 2; i++) begin
      xfer(sps[i], fbs[i], 8'd32, 8'd0, 8'd0, lat, rdy, lv);
      tests++;
      if (control_out !== m_out[0][7:0] || saturated !== m_sat[0]) begin
        fails++;
        $display("FAIL sat_%0d got %0d/%b exp %0d/%b", i,
                 control_out, saturated, m_out[0], m_sat[0]);
      end
    end
  endtask

  task automatic test_integral();
    int lat; bit rdy, lv;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      xfer(8'd50, 8'd40, 8'd0, 8'd16, 8'd0, lat, rdy, lv);
      tests++;
      if (control_out !== m_out[0][7:0] || saturated !== m_sat[0]) begin
        fails++;
        $display("FAIL integ_%0d got %0d/%b exp %0d/%b", i,
                 control_out, saturated, m_out[0], m_sat[0]);
      end
    end
    do_clear();
    xfer(8'd50, 8'd40, 8'd0, 8'd16, 8'd0, lat, rdy, lv);
    tests++;
    if (control_out !== m_out[0][7:0]) begin
      fails++;
      $display("FAIL integ_clear got %0d exp %0d", control_out, m_out[0]);
    end
  endtask

  task automatic test_int_clamp();
    int lat; bit rdy, lv;
    do_clear();
    xfer(8'd150, 8'd50, 8'd0, 8'd16, 8'd0, lat, rdy, lv);
    tests++;
    if (l_out !== m_out[1][7:0] || l_sat !== m_sat[1]) begin
      fails++;
      $display("FAIL clamp_lim got %0d/%b exp %0d/%b",
               l_out, l_sat, m_out[1], m_sat[1]);
    end
    tests++;
    if (control_out !== m_out[0][7:0]) begin
      fails++;
      $display("FAIL clamp_wide got %0d exp %0d", control_out, m_out[0]);
    end
  endtask

  task automatic test_derivative();
    int lat; bit rdy, lv;
    do_clear();
    for (int i = 0; i < 2; i++) begin
      xfer(8'd70, 8'd50, 8'd0, 8'd0, 8'd16, lat, rdy, lv);
      tests++;
      if (control_out !== m_out[0][7:0] || saturated !== m_sat[0]) begin
        fails++;
        $display("FAIL deriv_%0d got %0d/%b exp %0d/%b", i,
                 control_out, saturated, m_out[0], m_sat[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, ovs = 0;
    do_clear();
    @(negedge clk);
    setpoint = 8'd100; feedback = 8'd60;
    kp = 8'd32; ki = 8'd0; kd = 8'd0;
    sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (sample_ready === 1'b1) begin
        acc++;
        model_step(100, 60, 32, 0, 0);
      end
      @(posedge clk); #1;
      if (out_valid === 1'b1) ovs++;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) ovs++;
    end
    tests++;
    if (acc != 4) begin
      fails++; $display("FAIL b2b_accepts got %0d exp 4", acc);
    end
    tests++;
    if (ovs != 4) begin
      fails++; $display("FAIL b2b_pulses got %0d exp 4", ovs);
    end
    tests++;
    if (control_out !== m_out[0][7:0]) begin
      fails++;
      $display("FAIL b2b_out got %0d exp %0d", control_out, m_out[0]);
    end
  endtask

  task automatic test_clear_abort();
    int lat; bit rdy, lv;
    int ovs = 0;
    logic [7:0] held;
    held = control_out;
    @(negedge clk);
    setpoint = 8'd200; feedback = 8'd0; kp = 8'd200;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) ovs++;
    end
    tests++;
    if (ovs != 0 || control_out !== held) begin
      fails++;
      $display("FAIL clear_abort got ov=%0d out=%0d exp 0 %0d",
               ovs, control_out, held);
    end
    xfer(8'd50, 8'd40, 8'd0, 8'd16, 8'd0, lat, rdy, lv);
    tests++;
    if (control_out !== m_out[0][7:0]) begin
      fails++;
      $display("FAIL clear_next got %0d exp %0d", control_out, m_out[0]);
    end
  endtask

  task automatic test_reset_mid();
    int ovs = 0;
    @(negedge clk);
    setpoint = 8'd180; feedback = 8'd20;
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || control_out !== 8'd0 ||
        sample_ready !== 1'b1 || saturated !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got ov=%b out=%0d rdy=%b sat=%b exp 0 0 1 0",
               out_valid, control_out, sample_ready, saturated);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) ovs++;
    end
    tests++;
    if (ovs != 0) begin
      fails++; $display("FAIL reset_mid_ov got %0d exp 0", ovs);
    end
  endtask

  task automatic test_random();
    int lat; bit rdy, lv;
    logic [7:0] sp, fb, gp, gi, gd;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      sp = 8'($urandom_range(0, 255));
      fb = 8'($urandom_range(0, 255));
      gp = 8'($urandom_range(0, 40));
      gi = 8'($urandom_range(0, 24));
      gd = 8'($urandom_range(0, 40));
      xfer(sp, fb, gp, gi, gd, lat, rdy, lv);
      tests++;
      if (lat !== 5 || !rdy || !lv) begin
        fails++;
        $display("FAIL rnd_hs_%0d got lat=%0d rdy=%b lv=%b exp 5 1 1",
                 n, lat, rdy, lv);
      end
      tests++;
      if (control_out !== m_out[0][7:0] || saturated !== m_sat[0] ||
          l_out !== m_out[1][7:0] || l_sat !== m_sat[1]) begin
        fails++;
        $display("FAIL rnd_out_%0d got %0d/%b %0d/%b exp %0d/%b %0d/%b",
                 n, control_out, saturated, l_out, l_sat,
                 m_out[0], m_sat[0], m_out[1], m_sat[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prop();
    test_saturate();
    test_integral();
    test_int_clamp();
    test_derivative();
    test_back_to_back();
    test_clear_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
